stack_arb: RTL and testbench
============================

STACK_ARB -- requirements
Module: stack_arb

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the number of stack entries.
REQ-002 Parameter WIDTH, default 4, SHALL set the data word width.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  SHALL be the reset, asynchronous and active-low; rst=0 resets.
REQ-005 req0, req1  in  1  SHALL each be a level request from requester 0 or 1.
REQ-006 rw0, rw1  in  1  SHALL give the operation per requester: 1=push, 0=pop.
REQ-007 din0, din1  in  WIDTH  SHALL carry the push data per requester.
REQ-008 ack0, ack1  out  1  SHALL each be a one-cycle completion pulse per requester.
REQ-009 dout0, dout1  out  WIDTH  SHALL carry the popped data, valid while the matching ack is 1.
REQ-010 err0, err1  out  1  SHALL flag a rejected operation, valid while the matching ack is 1.
REQ-011 full, empty  out  1  SHALL give the stack status: count==DEPTH and count==0.
REQ-012 count  out  $clog2(DEPTH+1)  SHALL give the number of stored entries.
REQ-013 busy  out  1  SHALL be 1 in every state except IDLE.

Function
REQ-014 The FSM SHALL have three states, IDLE, SERVE and ACK, with fixed sequence IDLE->SERVE->ACK->IDLE.
REQ-015 In IDLE, with any req high, the block SHALL latch the grant index, rw and din of the winner and go to SERVE; with no req, it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: with both reqs high, the requester not served last wins; with one req high, that requester wins.
REQ-017 The last-served register SHALL update only when a grant is taken in IDLE.
REQ-018 In SERVE, a push with count<DEPTH SHALL write mem[count]=din and increment count.
REQ-019 In SERVE, a pop with count>0 SHALL capture mem[count-1] and decrement count.
REQ-020 A push with count==DEPTH SHALL leave memory and count unchanged and set err.
REQ-021 A pop with count==0 SHALL leave count unchanged, set err and return data 0.
REQ-022 In ACK, only the granted ack SHALL be 1 for exactly one cycle; its dout and err SHALL hold the SERVE result.
REQ-023 The non-granted ack, dout and err SHALL be 0.
REQ-024 Latency SHALL be 3 cycles from the IDLE sampling edge to the ack-high cycle; the minimum period per operation SHALL be 3 cycles.
REQ-025 A requester SHALL drop req after sampling its ack; a req still high in the following IDLE SHALL be treated as a new request.
REQ-026 req, rw and din changes during SERVE or ACK SHALL be ignored; only values latched in IDLE are used.
REQ-027 full, empty and count SHALL be registered and reflect the SERVE update from the ACK cycle onward.
REQ-028 Memory contents SHALL NOT be cleared by reset; count=0 makes them unreachable.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, count=0, empty=1, full=0, busy=0, all ack/err/dout=0, and last-served=1, so requester 0 wins the first tie.
REQ-030 Reset asserted during SERVE or ACK SHALL abort the operation with no ack and leave count=0.
REQ-031 After rst rises, the first grant SHALL be possible on the next rising edge.

Verification
REQ-032 Reset, then req0 pushes 4'hA -> ack0=1 three cycles later, err0=0, count=1, empty=0.
REQ-033 Push 1..16 from req1, then one more push -> 17th ack1 has err1=1, count=16, full=1; pop -> dout1=16, count=15.
REQ-034 Empty stack, req0 pop -> ack0 with err0=1, dout0=0, count=0, empty=1.
REQ-035 req0 and req1 held high, both pushing (din0=1, din1=2) -> acks alternate 0,1,0,1; after 4 ops, pops return 2,1,2,1.
REQ-036 rst pulled low during SERVE of a push -> no ack, count=0, busy=0 immediately; the next push stores at entry 0.
REQ-037 rw0/din0 changed during SERVE -> the stored value and operation match the IDLE-latched values.

Source files
------------

// File: rtl/stack_arb_if.sv
// Bundle of requester-side and status signals for stack_arb.
//   master : requester side (drives req/rw/din, observes ack/dout/err/status)
//   slave  : stack_arb side
// Signals:
//   req0/req1   level requests         rw0/rw1    1=push, 0=pop
//   din0/din1   push data              ack0/ack1  one-cycle completion pulses
//   dout0/dout1 popped data (with ack) err0/err1  rejected operation (with ack)
//   full/empty/count stack status      busy       controller not idle
interface stack_arb_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic             req0;
  logic             req1;
  logic             rw0;
  logic             rw1;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] dout0;
  logic [WIDTH-1:0] dout1;
  logic             err0;
  logic             err1;
  logic             full;
  logic             empty;
  logic [CntW-1:0]  count;
  logic             busy;

  modport master (
    output req0, req1, rw0, rw1, din0, din1,
    input  ack0, ack1, dout0, dout1, err0, err1, full, empty, count, busy
  );

  modport slave (
    input  req0, req1, rw0, rw1, din0, din1,
    output ack0, ack1, dout0, dout1, err0, err1, full, empty, count, busy
  );
endinterface

// File: rtl/stack_arb.sv
// Two-requester round-robin arbiter in front of a LIFO stack.
// Each operation walks IDLE -> SERVE -> ACK -> IDLE: the winner's rw/din are
// latched in IDLE, the stack is pushed/popped in SERVE, and the result is
// presented with a one-cycle ack in ACK.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : stack_arb_if slave modport (requests, acks, data, status)
module stack_arb #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 4
) (
  input logic       clk,
  input logic       rst,
  stack_arb_if.slave bus
);

  localparam int unsigned     CntW     = $clog2(DEPTH + 1);
  localparam int unsigned     AddrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StServe, StAck} state_e;

  state_e state_q, state_d;

  logic             gnt_q, gnt_d;     // granted requester index
  logic             last_q, last_d;   // last-served requester
  logic             rw_q, rw_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             mem_we;
  logic [AddrW-1:0] wr_addr;
  logic [AddrW-1:0] rd_addr;

  logic any_req;
  logic win;
  logic in_ack;

  assign any_req = bus.req0 | bus.req1;
  // On a tie the requester not served last wins; otherwise the lone requester.
  assign win     = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StServe;
      StServe: state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: grant latch in IDLE, stack update in SERVE
  always_comb begin
    gnt_d   = gnt_q;
    last_d  = last_q;
    rw_d    = rw_q;
    din_d   = din_q;
    count_d = count_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    wr_addr = AddrW'(count_q);
    rd_addr = AddrW'(count_q - CntW'(1));

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_d  = win;
          last_d = win;
          rw_d   = win ? bus.rw1 : bus.rw0;
          din_d  = win ? bus.din1 : bus.din0;
        end
      end
      StServe: begin
        rdata_d = '0;
        if (rw_q) begin
          if (count_q != DepthCnt) begin
            mem_we  = 1'b1;
            count_d = count_q + CntW'(1);
            err_d   = 1'b0;
          end else begin
            err_d   = 1'b1;
          end
        end else begin
          if (count_q != '0) begin
            rdata_d = mem[rd_addr];
            count_d = count_q - CntW'(1);
            err_d   = 1'b0;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase

    full_d  = (count_d == DepthCnt);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;  // requester 0 wins the first tie
      rw_q    <= 1'b0;
      din_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      din_q   <= din_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset; count=0 makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= din_q;
    end
  end

  // Outputs
  assign in_ack = (state_q == StAck);

  always_comb begin
    bus.busy  = (state_q != StIdle);
    bus.ack0  = in_ack & ~gnt_q;
    bus.ack1  = in_ack & gnt_q;
    bus.dout0 = (in_ack & ~gnt_q) ? rdata_q : '0;
    bus.dout1 = (in_ack & gnt_q) ? rdata_q : '0;
    bus.err0  = in_ack & ~gnt_q & err_q;
    bus.err1  = in_ack & gnt_q & err_q;
    bus.full  = full_q;
    bus.empty = empty_q;
    bus.count = count_q;
  end

endmodule

// File: tb/tb_stack_arb.sv
module tb_stack_arb;

  localparam int unsigned DEPTH = 16;
  // Wider than the default so that pushed values 16 and 17 stay distinct.
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stack_arb_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  stack_arb #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one transaction at a time; a grant is decided at the
  // sampling edge, the result becomes visible two edges later for one cycle.
  logic [WIDTH-1:0] m_stack[$];
  int               m_age  = 0;   // edges since grant (0 = free)
  bit               m_last = 1'b1;
  bit               m_who  = 1'b0;
  bit               m_err  = 1'b0;
  bit               m_rw   = 1'b0;
  logic [WIDTH-1:0] m_din  = '0;
  logic [WIDTH-1:0] m_data = '0;
  int               m_vis  = 0;   // externally visible count

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_stack.delete();
      m_age  = 0;
      m_last = 1'b1;
      m_vis  = 0;
    end else if (m_age == 0) begin
      if (bus.req0 || bus.req1) begin
        m_who  = (bus.req0 && bus.req1) ? !m_last : bus.req1;
        m_last = m_who;
        m_rw   = m_who ? bus.rw1 : bus.rw0;
        m_din  = m_who ? bus.din1 : bus.din0;
        m_data = '0;
        if (m_rw) begin
          m_err = (m_stack.size() >= DEPTH);
          if (!m_err) m_stack.push_back(m_din);
        end else begin
          m_err = (m_stack.size() == 0);
          if (!m_err) m_data = m_stack.pop_back();
        end
        m_age = 1;
      end
    end else if (m_age == 1) begin
      m_age = 2;
      m_vis = m_stack.size();
    end else begin
      m_age = 0;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ack0",  32'(bus.ack0),  32'(m_age == 2 && !m_who));
      check("ack1",  32'(bus.ack1),  32'(m_age == 2 && m_who));
      check("dout0", 32'(bus.dout0), 32'((m_age == 2 && !m_who) ? m_data : '0));
      check("dout1", 32'(bus.dout1), 32'((m_age == 2 && m_who) ? m_data : '0));
      check("err0",  32'(bus.err0),  32'(m_age == 2 && !m_who && m_err));
      check("err1",  32'(bus.err1),  32'(m_age == 2 && m_who && m_err));
      check("count", 32'(bus.count), 32'(m_vis));
      check("full",  32'(bus.full),  32'(m_vis == DEPTH));
      check("empty", 32'(bus.empty), 32'(m_vis == 0));
      check("busy",  32'(bus.busy),  32'(m_age != 0));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One operation from one requester; starts and ends just after a rising edge.
  task automatic do_op(input bit who, input bit rw, input logic [WIDTH-1:0] d,
                       output logic [WIDTH-1:0] q, output bit e, output int lat);
    bit got = 1'b0;
    if (who) begin
      bus.req1 = 1'b1; bus.rw1 = rw; bus.din1 = d;
    end else begin
      bus.req0 = 1'b1; bus.rw0 = rw; bus.din0 = d;
    end
    q   = '0;
    e   = 1'b0;
    lat = 0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      got = who ? bus.ack1 : bus.ack0;
    end
    if (got) begin
      q = who ? bus.dout1 : bus.dout0;
      e = who ? bus.err1 : bus.err0;
    end else begin
      n_checks++;
      n_err++;
      $display("FAIL ack_timeout: got no ack, want ack within 10 cycles (t=%0t)", $time);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] q;
    bit               e;
    int               lat;
    int               n;
    bit               order[4];
    bit               got;

    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.rw0  = 1'b0; bus.rw1  = 1'b0;
    bus.din0 = '0;   bus.din1 = '0;

    // Reset values while reset is held
    #3 rst = 1'b0;
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_ack0",  32'(bus.ack0),  32'd0);
    check("rst_ack1",  32'(bus.ack1),  32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // First push: three-cycle latency
    do_op(1'b0, 1'b1, 8'hA, q, e, lat);
    check("push_latency", 32'(lat), 32'd3);
    check("push_err0",    32'(e), 32'd0);
    check("push_count",   32'(bus.count), 32'd1);
    check("push_empty",   32'(bus.empty), 32'd0);

    // Pop from empty stack
    do_reset();
    do_op(1'b0, 1'b0, '0, q, e, lat);
    check("underflow_err0",  32'(e), 32'd1);
    check("underflow_dout0", 32'(q), 32'd0);
    check("underflow_count", 32'(bus.count), 32'd0);
    check("underflow_empty", 32'(bus.empty), 32'd1);

    // Fill, overflow, pop top
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      do_op(1'b1, 1'b1, WIDTH'(i), q, e, lat);
    end
    do_op(1'b1, 1'b1, 8'd17, q, e, lat);
    check("overflow_err1",  32'(e), 32'd1);
    check("overflow_count", 32'(bus.count), 32'd16);
    check("overflow_full",  32'(bus.full), 32'd1);
    do_op(1'b1, 1'b0, '0, q, e, lat);
    check("top_dout1", 32'(q), 32'd16);
    check("top_count", 32'(bus.count), 32'd15);

    // Round-robin with both requesters pushing continuously
    do_reset();
    bus.rw0 = 1'b1; bus.rw1 = 1'b1;
    bus.din0 = 8'd1; bus.din1 = 8'd2;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        order[n] = bus.ack1;
        n++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("rr_ops", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) check("rr_order", 32'(order[i]), 32'(i % 2));
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, 1'b0, '0, q, e, lat);
      check("rr_pop", 32'(q), (i % 2 == 0) ? 32'd2 : 32'd1);
    end

    // Reset during SERVE aborts the push
    do_reset();
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.din0 = 8'h5;
    @(negedge clk);
    @(negedge clk);
    check("serve_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1 bus.req0 = 1'b0;
    check("abort_busy",  32'(bus.busy),  32'd0);
    check("abort_count", 32'(bus.count), 32'd0);
    check("abort_ack0",  32'(bus.ack0),  32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    do_op(1'b0, 1'b1, 8'h9, q, e, lat);
    check("abort_push_count", 32'(bus.count), 32'd1);
    do_op(1'b0, 1'b0, '0, q, e, lat);
    check("abort_pop_dout", 32'(q), 32'h9);

    // Inputs changed during SERVE are ignored
    do_reset();
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.din0 = 8'h3;
    @(negedge clk);
    @(negedge clk);
    bus.rw0 = 1'b0; bus.din0 = 8'h7;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = bus.ack0;
    end
    check("latch_ack0",  32'(got), 32'd1);
    check("latch_err0",  32'(bus.err0), 32'd0);
    check("latch_count", 32'(bus.count), 32'd1);
    bus.req0 = 1'b0;
    @(posedge clk);
    #1;
    do_op(1'b0, 1'b0, '0, q, e, lat);
    check("latch_pop", 32'(q), 32'h3);

    // Random traffic against the model, with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        bus.req0 = ($urandom_range(0, 99) < 60);
        bus.req1 = ($urandom_range(0, 99) < 60);
        bus.rw0  = ($urandom_range(0, 99) < ((i < 300) ? 75 : 30));
        bus.rw1  = ($urandom_range(0, 99) < ((i < 300) ? 75 : 30));
        bus.din0 = WIDTH'($urandom);
        bus.din1 = WIDTH'($urandom);
        @(posedge clk);
        #1;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
